dcache_dm: RTL and testbench
============================

# dcache_dm

Direct-mapped, write-back, write-allocate data cache that responds to the memory stage's `dmemREN`/`dmemWEN` requests with `dhit`, the signal the EX/MEM latch waits on before advancing a memory op. It sits between the datapath's memory stage and the memory-side bus (`dREN`/`dWEN`/`dwait`). On `halt` it writes every dirty frame back, then raises `flushed`. There is no coherence logic; each core instantiates one cache.

## Interface
Parameters: none; geometry is fixed by package constants (8 sets, 2 words per block).

- CLK  in  1  clock, rising edge
- nRST  in  1  reset; asynchronous, active-low
- dmemREN  in  1  datapath load request
- dmemWEN  in  1  datapath store request; never asserted together with dmemREN
- dmemaddr  in  32  byte address; bits [1:0] ignored
- dmemstore  in  32  store data
- halt  in  1  datapath halted; starts the flush
- dhit  out  1  request serviced this cycle
- dmemload  out  32  load data, valid while dhit=1
- flushed  out  1  flush complete; held until reset
- dwait  in  1  memory busy; a transfer completes on a cycle with dwait=0
- dload  in  32  memory read data
- dREN  out  1  memory read request
- dWEN  out  1  memory write request
- daddr  out  32  memory word address, bits [1:0]=00
- dstore  out  32  memory write data

## Operation
- Address split: tag [31:6] (26 bits), idx [5:3], blkoff [2], bytoff [1:0].
- Frame contents: valid, dirty, tag, two data words.
- Hit: in IDLE, a hit is valid[idx] & tag match & (dmemREN|dmemWEN).
  - Load hit: dhit=1 combinationally; dmemload = data[idx][blkoff].
  - Store hit: dhit=1; at the clock edge the addressed word is written and dirty is set.
- FSM states: IDLE, WB0, WB1, LD0, LD1, FL_CHK, FL_WB0, FL_WB1, DONE.
- IDLE transitions:
  - halt=1 → FL_CHK with set counter=0. Halt has priority over any request.
  - Miss with the victim dirty → WB0.
  - Miss with the victim clean → LD0.
- Writeback:
  - WB0: dWEN=1, daddr={victim tag, idx, 0, 00}, dstore=word0. Advance to WB1 when dwait=0.
  - WB1: same with blkoff=1 and word1. Advance to LD0 when dwait=0.
- Fill:
  - LD0: dREN=1, daddr={req tag, idx, 0, 00}. Latch dload into word0 when dwait=0, then go to LD1.
  - LD1: same for word1. When dwait=0, set valid=1, dirty=0, tag=req tag, then go to IDLE.
  - The request hits on the following cycle.
- dhit=0 in every state except a hitting IDLE cycle.
- Flush:
  - FL_CHK: if frame[cnt] is valid & dirty → FL_WB0. Otherwise increment cnt; after set 7 → DONE.
  - FL_WB0 and FL_WB1 are as WB0 and WB1 but for frame[cnt]. After FL_WB1 completes, clear dirty, increment cnt, and return to FL_CHK (or go to DONE after set 7).
- DONE: flushed=1, no memory requests, dhit=0. The state is terminal.

## Timing
- Reset values:
  - All frames: valid=0, dirty=0.
  - State=IDLE, cnt=0.
  - dhit=0, dmemload=0, flushed=0, dREN=0, dWEN=0, daddr=0, dstore=0.
- Hit latency is 0 cycles (same-cycle dhit).
- Clean miss: at least 2 memory transfers, with dhit one cycle after LD1 completes. With dwait low throughout, dhit comes 3 cycles after the request.
- Dirty miss: 4 transfers. With dwait low throughout, dhit comes 5 cycles after the request.
- The request inputs must remain stable until dhit. The cache latches the request tag and index on leaving IDLE.
- The memory bus outputs are combinational from the state. They are held stable while dwait=1.
- Reset mid-transfer: the FSM returns to IDLE, all frames are invalidated, and any request in flight is dropped with no partial fill visible.
- Flush of a clean cache takes 8 FL_CHK cycles before DONE.

## Structure
- cpu_types_pkg (shared) gains the following; `word_t` already exists there and is reused:
  - constants DSETS=8, DWORDS=2, DTAG_W=26;
  - typedef `dcachef_t` (tag, idx, blkoff, bytoff);
  - typedef `dframe_t` (valid, dirty, tag, data[2]);
  - enum `dcache_state_t`.
- No sub-module. The frame array, FSM and output logic are inline, with the frame array as an 8-entry array of dframe_t.

## Test plan
- Reset, then load of 0x100. Expected: LD0/LD1 read 0x100 and 0x104 (dload 0xAAAA, 0xBBBB), then dhit=1 with dmemload=0xAAAA. A second load of 0x104 gives dhit the same cycle with 0xBBBB.
- Store 0x12345678 to 0x100 after the fill. Expected: dhit same cycle; a later load returns 0x12345678; no bus traffic.
- Dirty conflict: load 0x140 (same idx 0, tag differs) after the store. Expected:
  - WB0 writes 0x12345678 to 0x100, WB1 writes 0xBBBB to 0x104;
  - then LD0/LD1 read 0x140 and 0x144.
- dwait held high for 3 cycles during LD0. Expected: daddr/dREN stay stable, dhit stays 0, and the fill completes only after dwait drops.
- Halt with sets 0 and 5 dirty. Expected: exactly 4 dWEN transfers to the set-0 and set-5 addresses, then flushed=1 held; later requests get no dhit.
- nRST asserted mid-LD1. Expected: all outputs 0 immediately; a reload of the same address misses.

Source files
------------

// File: rtl/cpu_types_pkg.sv
// Shared CPU types plus the data-cache geometry, address split, frame layout
// and FSM states used by dcache_dm.
package cpu_types_pkg;

    typedef logic [31:0] word_t;

    localparam int DSETS  = 8;
    localparam int DWORDS = 2;
    localparam int DTAG_W = 26;
    localparam int DIDX_W = 3;

    typedef struct packed {
        logic [DTAG_W-1:0] tag;
        logic [DIDX_W-1:0] idx;
        logic              blkoff;
        logic [1:0]        bytoff;
    } dcachef_t;

    typedef struct packed {
        logic                     valid;
        logic                     dirty;
        logic [DTAG_W-1:0]        tag;
        word_t [DWORDS-1:0]       data;
    } dframe_t;

    typedef enum logic [3:0] {
        IDLE,
        WB0,
        WB1,
        LD0,
        LD1,
        FL_CHK,
        FL_WB0,
        FL_WB1,
        DONE
    } dcache_state_t;

endpackage

// File: rtl/dcache_dm_if.sv
// Datapath-side request/response and memory-side bus signals of dcache_dm.
interface dcache_dm_if;
    import cpu_types_pkg::*;

    logic  dmemREN, dmemWEN, halt, dhit, flushed;
    word_t dmemaddr, dmemstore, dmemload;
    logic  dwait, dREN, dWEN;
    word_t dload, daddr, dstore;

    modport slave (
        input  dmemREN, dmemWEN, dmemaddr, dmemstore, halt, dwait, dload,
        output dhit, dmemload, flushed, dREN, dWEN, daddr, dstore
    );

    modport master (
        output dmemREN, dmemWEN, dmemaddr, dmemstore, halt, dwait, dload,
        input  dhit, dmemload, flushed, dREN, dWEN, daddr, dstore
    );

endinterface

// File: rtl/dcache_dm.sv
// Direct-mapped write-back/write-allocate data cache with a flush-on-halt
// sequencer that writes every dirty frame back before raising flushed.
module dcache_dm
    import cpu_types_pkg::*;
(
    input  logic       CLK,
    input  logic       nRST,
    dcache_dm_if.slave bus
);

    dframe_t           frames_q [DSETS];
    dcache_state_t     state_q, state_d;
    logic [DIDX_W-1:0] cnt_q, cnt_d;
    logic [DIDX_W-1:0] req_idx_q, req_idx_d;
    logic [DTAG_W-1:0] req_tag_q, req_tag_d;

    dcachef_t          addr;
    logic              req, hit, victim_dirty, flush_dirty, last_set, xfer_done;
    logic [DIDX_W-1:0] wb_idx;
    logic              unused_bytoff;

    assign addr          = dcachef_t'(bus.dmemaddr);
    assign unused_bytoff = ^addr.bytoff;
    assign req           = bus.dmemREN | bus.dmemWEN;
    // halt wins over a request, so a hitting request is not serviced while halt is up
    assign hit           = (state_q == IDLE) && !bus.halt && req &&
                           frames_q[addr.idx].valid && (frames_q[addr.idx].tag == addr.tag);
    assign victim_dirty  = frames_q[addr.idx].valid && frames_q[addr.idx].dirty;
    assign flush_dirty   = frames_q[cnt_q].valid && frames_q[cnt_q].dirty;
    assign last_set      = &cnt_q;
    assign xfer_done     = !bus.dwait;
    assign wb_idx        = (state_q == FL_WB0 || state_q == FL_WB1) ? cnt_q : req_idx_q;

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            req_idx_q <= '0;
            req_tag_q <= '0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            req_idx_q <= req_idx_d;
            req_tag_q <= req_tag_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        req_idx_d = req_idx_q;
        req_tag_d = req_tag_q;
        case (state_q)
            IDLE: begin
                req_tag_d = addr.tag;
                req_idx_d = addr.idx;
                if (bus.halt) begin
                    state_d = FL_CHK;
                    cnt_d   = '0;
                end else if (req && !hit) begin
                    state_d = victim_dirty ? WB0 : LD0;
                end
            end
            WB0:    if (xfer_done) state_d = WB1;
            WB1:    if (xfer_done) state_d = LD0;
            LD0:    if (xfer_done) state_d = LD1;
            LD1:    if (xfer_done) state_d = IDLE;
            FL_CHK: begin
                if (flush_dirty) begin
                    state_d = FL_WB0;
                end else begin
                    cnt_d   = cnt_q + 1'b1;
                    state_d = last_set ? DONE : FL_CHK;
                end
            end
            FL_WB0: if (xfer_done) state_d = FL_WB1;
            FL_WB1: begin
                if (xfer_done) begin
                    cnt_d   = cnt_q + 1'b1;
                    state_d = last_set ? DONE : FL_CHK;
                end
            end
            DONE:    state_d = DONE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        bus.dhit     = hit;
        bus.dmemload = hit ? frames_q[addr.idx].data[addr.blkoff] : '0;
        bus.flushed  = (state_q == DONE);
        bus.dREN     = 1'b0;
        bus.dWEN     = 1'b0;
        bus.daddr    = '0;
        bus.dstore   = '0;
        case (state_q)
            WB0, FL_WB0: begin
                bus.dWEN   = 1'b1;
                bus.daddr  = {frames_q[wb_idx].tag, wb_idx, 1'b0, 2'b00};
                bus.dstore = frames_q[wb_idx].data[0];
            end
            WB1, FL_WB1: begin
                bus.dWEN   = 1'b1;
                bus.daddr  = {frames_q[wb_idx].tag, wb_idx, 1'b1, 2'b00};
                bus.dstore = frames_q[wb_idx].data[1];
            end
            LD0: begin
                bus.dREN  = 1'b1;
                bus.daddr = {req_tag_q, req_idx_q, 1'b0, 2'b00};
            end
            LD1: begin
                bus.dREN  = 1'b1;
                bus.daddr = {req_tag_q, req_idx_q, 1'b1, 2'b00};
            end
            default: ;
        endcase
    end

    // Frame becomes valid only on the second fill beat, so an interrupted fill never hits.
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            for (int i = 0; i < DSETS; i++) frames_q[i] <= '0;
        end else begin
            if (hit && bus.dmemWEN) begin
                frames_q[addr.idx].data[addr.blkoff] <= bus.dmemstore;
                frames_q[addr.idx].dirty             <= 1'b1;
            end
            if (state_q == LD0 && xfer_done)
                frames_q[req_idx_q].data[0] <= bus.dload;
            if (state_q == LD1 && xfer_done) begin
                frames_q[req_idx_q].data[1] <= bus.dload;
                frames_q[req_idx_q].valid   <= 1'b1;
                frames_q[req_idx_q].dirty   <= 1'b0;
                frames_q[req_idx_q].tag     <= req_tag_q;
            end
            if (state_q == FL_WB1 && xfer_done)
                frames_q[cnt_q].dirty <= 1'b0;
        end
    end

endmodule

// File: tb/tb_dcache_dm.sv
// Scoreboard bench for dcache_dm: stimulus queues expected hits and bus
// transfers, a negedge monitor pops and compares them as the DUT produces them.
module tb_dcache_dm;
    import cpu_types_pkg::*;

    logic CLK = 1'b0;
    logic nRST;
    always #5 CLK = ~CLK;

    dcache_dm_if bus();
    dcache_dm dut (.CLK(CLK), .nRST(nRST), .bus(bus));

    int tests = 0;
    int fails = 0;

    // kind: 0 = dhit, 1 = memory read, 2 = memory write
    typedef struct {
        int    kind;
        word_t addr;
        word_t data;
        bit    chk_data;
    } ev_t;
    ev_t expq[$];

    function automatic word_t mem_rd(word_t a);
        case (a)
            32'h100: return 32'h0000_AAAA;
            32'h104: return 32'h0000_BBBB;
            32'h140: return 32'h0000_CCCC;
            32'h144: return 32'h0000_DDDD;
            default: return 32'hD000_0000 | a;
        endcase
    endfunction

    always_comb bus.dload = mem_rd(bus.daddr);

    function automatic void exp_push(int k, word_t a, word_t d, bit c);
        ev_t e;
        e.kind = k; e.addr = a; e.data = d; e.chk_data = c;
        expq.push_back(e);
    endfunction

    task automatic check_eq(string name, word_t act, word_t exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic mon_ev(int kind, word_t a, word_t d);
        ev_t e;
        tests++;
        if (expq.size() == 0) begin
            fails++;
            $display("FAIL unexpected_event: got kind=%0d addr=%h data=%h, expected nothing", kind, a, d);
        end else begin
            e = expq.pop_front();
            if (e.kind != kind || e.addr != a || (e.chk_data && e.data != d)) begin
                fails++;
                $display("FAIL event: got kind=%0d addr=%h data=%h, expected kind=%0d addr=%h data=%h",
                         kind, a, d, e.kind, e.addr, e.data);
            end else begin
                $display("[TB] event kind=%0d addr=%h data=%h ok", kind, a, d);
            end
        end
    endtask

    always @(negedge CLK) begin
        if (nRST === 1'b1) begin
            if (bus.dhit)
                mon_ev(0, bus.dmemaddr, bus.dmemload);
            else if ((bus.dREN || bus.dWEN) && !bus.dwait)
                mon_ev(bus.dWEN ? 2 : 1, bus.daddr, bus.dstore);
        end
    end

    task automatic do_req(string name, bit w, word_t a, word_t sd, int exp_lat);
        int lat = 0;
        @(posedge CLK); #1;
        bus.dmemREN = !w; bus.dmemWEN = w; bus.dmemaddr = a; bus.dmemstore = sd;
        @(negedge CLK);
        while (!bus.dhit && lat < 60) begin
            @(negedge CLK);
            lat++;
        end
        check_eq(name, word_t'(lat), word_t'(exp_lat));
        @(posedge CLK); #1;
        bus.dmemREN = 1'b0; bus.dmemWEN = 1'b0;
    endtask

    task automatic check_idle_outputs(string tag);
        check_eq({tag, "_ctrl"}, word_t'({bus.dhit, bus.flushed, bus.dREN, bus.dWEN}), 32'h0);
        check_eq({tag, "_dmemload"}, bus.dmemload, 32'h0);
        check_eq({tag, "_daddr"}, bus.daddr, 32'h0);
        check_eq({tag, "_dstore"}, bus.dstore, 32'h0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        int hits;
        nRST = 1'b0;
        bus.dmemREN = 1'b0; bus.dmemWEN = 1'b0; bus.dmemaddr = '0; bus.dmemstore = '0;
        bus.halt = 1'b0; bus.dwait = 1'b0;
        repeat (2) @(posedge CLK);
        #1 check_idle_outputs("reset");
        @(negedge CLK) nRST = 1'b1;

        // clean miss fill, then hit on the other word
        exp_push(1, 32'h100, 0, 0); exp_push(1, 32'h104, 0, 0); exp_push(0, 32'h100, 32'hAAAA, 1);
        do_req("lat_clean_miss", 0, 32'h100, 0, 3);
        exp_push(0, 32'h104, 32'hBBBB, 1);
        do_req("lat_load_hit", 0, 32'h104, 0, 0);

        // store hit, then read back
        exp_push(0, 32'h100, 0, 0);
        do_req("lat_store_hit", 1, 32'h100, 32'h1234_5678, 0);
        exp_push(0, 32'h100, 32'h1234_5678, 1);
        do_req("lat_load_after_store", 0, 32'h100, 0, 0);

        // dirty conflict on set 0
        exp_push(2, 32'h100, 32'h1234_5678, 1); exp_push(2, 32'h104, 32'hBBBB, 1);
        exp_push(1, 32'h140, 0, 0); exp_push(1, 32'h144, 0, 0); exp_push(0, 32'h140, 32'hCCCC, 1);
        do_req("lat_dirty_miss", 0, 32'h140, 0, 5);

        // dwait held high for 3 LD0 cycles
        exp_push(1, 32'h180, 0, 0); exp_push(1, 32'h184, 0, 0); exp_push(0, 32'h180, 32'hD000_0180, 1);
        bus.dwait = 1'b1;
        fork
            do_req("lat_stalled_miss", 0, 32'h180, 0, 6);
            begin
                @(posedge CLK);
                @(negedge CLK);
                for (int i = 0; i < 3; i++) begin
                    @(negedge CLK);
                    check_eq("stall_dREN", word_t'(bus.dREN), 32'h1);
                    check_eq("stall_daddr", bus.daddr, 32'h180);
                    check_eq("stall_dhit", word_t'(bus.dhit), 32'h0);
                end
                @(posedge CLK); #1 bus.dwait = 1'b0;
            end
        join

        // make sets 5 and 0 dirty, then flush
        exp_push(1, 32'h228, 0, 0); exp_push(1, 32'h22C, 0, 0); exp_push(0, 32'h22C, 0, 0);
        do_req("lat_store_miss", 1, 32'h22C, 32'h55, 3);
        exp_push(0, 32'h180, 0, 0);
        do_req("lat_store_hit2", 1, 32'h180, 32'h77, 0);
        exp_push(2, 32'h180, 32'h77, 1); exp_push(2, 32'h184, 32'hD000_0184, 1);
        exp_push(2, 32'h228, 32'hD000_0228, 1); exp_push(2, 32'h22C, 32'h55, 1);
        @(posedge CLK); #1 bus.halt = 1'b1;
        n = 0;
        @(negedge CLK);
        while (!bus.flushed && n < 200) begin
            @(negedge CLK);
            n++;
        end
        check_eq("flushed_set", word_t'(bus.flushed), 32'h1);
        check_eq("flush_all_writes_seen", word_t'(expq.size()), 32'h0);
        @(posedge CLK); #1;
        bus.dmemREN = 1'b1; bus.dmemaddr = 32'h180;
        hits = 0;
        for (int i = 0; i < 10; i++) begin
            @(negedge CLK);
            if (bus.dhit || bus.dREN || bus.dWEN) hits++;
        end
        check_eq("done_no_activity", word_t'(hits), 32'h0);
        check_eq("flushed_held", word_t'(bus.flushed), 32'h1);

        // plain reset to leave DONE
        #1 nRST = 1'b0;
        bus.dmemREN = 1'b0; bus.halt = 1'b0;
        @(posedge CLK);
        @(negedge CLK) nRST = 1'b1;

        // reset asserted mid-LD1
        exp_push(1, 32'h300, 0, 0); exp_push(1, 32'h304, 0, 0);
        @(posedge CLK); #1;
        bus.dmemREN = 1'b1; bus.dmemaddr = 32'h300;
        @(posedge CLK);
        @(posedge CLK); #1 bus.dwait = 1'b1;
        @(negedge CLK);
        check_eq("ld1_dREN", word_t'(bus.dREN), 32'h1);
        check_eq("ld1_daddr", bus.daddr, 32'h304);
        #1 nRST = 1'b0;
        #1 check_idle_outputs("midreset");
        bus.dmemREN = 1'b0;
        @(posedge CLK);
        @(negedge CLK);
        nRST = 1'b1; bus.dwait = 1'b0;
        check_eq("midreset_pending", word_t'(expq.size()), 32'h1);
        expq.delete();
        exp_push(1, 32'h300, 0, 0); exp_push(1, 32'h304, 0, 0); exp_push(0, 32'h300, 32'hD000_0300, 1);
        do_req("lat_reload_miss", 0, 32'h300, 0, 3);

        repeat (2) @(negedge CLK);
        check_eq("final_queue_empty", word_t'(expq.size()), 32'h0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
